// File: rtl/z_trap_sequencer.sv
// Trap sequencer: turns a detected exception into a CSR write plus fetch redirect,
// and turns a retiring MRET into a redirect back to mepc.
module z_trap_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  z_clk,
  input  logic                  z_rst,
  input  logic                  exception_valid_i,
  input  logic [7:0]            exception_id_i,
  input  logic [PC_WIDTH-1:0]   exception_pc_i,
  input  logic [DATA_WIDTH-1:0] exception_tval_i,
  input  logic [DATA_WIDTH-1:0] exception_handler_addr_i,
  input  logic                  mret_valid_i,
  input  logic [PC_WIDTH-1:0]   csr_mepc_i,
  input  logic                  stall_valid_i,
  input  logic                  debug_mode_valid_i,
  output logic                  csr_trap_we_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  output logic [PC_WIDTH-1:0]   csr_mepc_o,
  output logic [DATA_WIDTH-1:0] csr_mtval_o,
  output logic                  mstatus_mie_o,
  output logic                  mstatus_mpie_o,
  output logic                  flush_o,
  output logic                  pc_redirect_valid_o,
  output logic [PC_WIDTH-1:0]   pc_redirect_addr_o,
  output logic                  trap_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_CAPTURE  = 2'b01,
    S_REDIRECT = 2'b10,
    S_RETURN   = 2'b11
  } state_t;

  localparam logic [7:0] ECALL_ID = 8'd11;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_sample;
  logic                  w_take_trap;
  logic                  w_take_mret;
  logic                  w_next_active;
  logic [PC_WIDTH-1:0]   r_target;
  logic                  r_trap_we;
  logic [DATA_WIDTH-1:0] r_mcause;
  logic [PC_WIDTH-1:0]   r_mepc;
  logic [DATA_WIDTH-1:0] r_mtval;
  logic                  r_mie;
  logic                  r_mpie;
  logic                  r_flush;
  logic                  r_redirect_valid;
  logic [PC_WIDTH-1:0]   r_redirect_addr;
  logic                  r_busy;

  // Request qualification; exception has priority over MRET.
  always_comb begin
    w_sample      = ~stall_valid_i & ~debug_mode_valid_i;
    w_take_trap   = w_sample & exception_valid_i;
    w_take_mret   = w_sample & mret_valid_i & ~exception_valid_i;
    w_next_active = (w_state_next != S_IDLE);
  end

  // State register.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; only IDLE looks at requests, the other states always complete.
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_take_trap) begin
          w_state_next = S_CAPTURE;
        end else if (w_take_mret) begin
          w_state_next = S_RETURN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CAPTURE:  w_state_next = S_REDIRECT;
      S_REDIRECT: w_state_next = S_IDLE;
      S_RETURN:   w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_trap_we        <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_busy           <= 1'b0;
      r_mcause         <= {DATA_WIDTH{1'b0}};
      r_mepc           <= {PC_WIDTH{1'b0}};
      r_mtval          <= {DATA_WIDTH{1'b0}};
      r_target         <= {PC_WIDTH{1'b0}};
      r_redirect_addr  <= {PC_WIDTH{1'b0}};
    end else begin
      r_trap_we        <= (w_state_next == S_CAPTURE);
      r_redirect_valid <= (w_state_next == S_REDIRECT) || (w_state_next == S_RETURN);
      r_flush          <= w_next_active;
      r_busy           <= w_next_active;
      if (w_state_next == S_CAPTURE) begin
        r_mcause <= DATA_WIDTH'(exception_id_i);
        r_mepc   <= {exception_pc_i[PC_WIDTH-1:2], 2'b00};
        r_mtval  <= (exception_id_i == ECALL_ID) ? {DATA_WIDTH{1'b0}} : exception_tval_i;
        r_target <= PC_WIDTH'(exception_handler_addr_i);
      end
      if (w_state_next == S_REDIRECT) begin
        r_redirect_addr <= r_target;
      end else if (w_state_next == S_RETURN) begin
        r_redirect_addr <= csr_mepc_i;
      end
    end
  end

  // mstatus interrupt-enable stack: push on trap entry, pop on MRET.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (r_state == S_RETURN) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end
  end

  assign csr_trap_we_o       = r_trap_we;
  assign csr_mcause_o        = r_mcause;
  assign csr_mepc_o          = r_mepc;
  assign csr_mtval_o         = r_mtval;
  assign mstatus_mie_o       = r_mie;
  assign mstatus_mpie_o      = r_mpie;
  assign flush_o             = r_flush;
  assign pc_redirect_valid_o = r_redirect_valid;
  assign pc_redirect_addr_o  = r_redirect_addr;
  assign trap_busy_o         = r_busy;

endmodule

// File: tb/tb_z_trap_sequencer.sv
// Scoreboard bench for z_trap_sequencer: expected CSR writes and redirects are queued
// when stimulus is applied and retired when the DUT strobes them.
module tb_z_trap_sequencer;

  logic        z_clk = 1'b0;
  logic        z_rst;
  logic        exception_valid_i;
  logic [7:0]  exception_id_i;
  logic [31:0] exception_pc_i;
  logic [31:0] exception_tval_i;
  logic [31:0] exception_handler_addr_i;
  logic        mret_valid_i;
  logic [31:0] csr_mepc_i;
  logic        stall_valid_i;
  logic        debug_mode_valid_i;
  logic        csr_trap_we_o;
  logic [31:0] csr_mcause_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mtval_o;
  logic        mstatus_mie_o;
  logic        mstatus_mpie_o;
  logic        flush_o;
  logic        pc_redirect_valid_o;
  logic [31:0] pc_redirect_addr_o;
  logic        trap_busy_o;

  typedef struct {
    logic        is_redir;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] addr;
    logic        mie;
    logic        mpie;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic m_mie;
  logic m_mpie;

  z_trap_sequencer #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .z_clk                    (z_clk),
    .z_rst                    (z_rst),
    .exception_valid_i        (exception_valid_i),
    .exception_id_i           (exception_id_i),
    .exception_pc_i           (exception_pc_i),
    .exception_tval_i         (exception_tval_i),
    .exception_handler_addr_i (exception_handler_addr_i),
    .mret_valid_i             (mret_valid_i),
    .csr_mepc_i               (csr_mepc_i),
    .stall_valid_i            (stall_valid_i),
    .debug_mode_valid_i       (debug_mode_valid_i),
    .csr_trap_we_o            (csr_trap_we_o),
    .csr_mcause_o             (csr_mcause_o),
    .csr_mepc_o               (csr_mepc_o),
    .csr_mtval_o              (csr_mtval_o),
    .mstatus_mie_o            (mstatus_mie_o),
    .mstatus_mpie_o           (mstatus_mpie_o),
    .flush_o                  (flush_o),
    .pc_redirect_valid_o      (pc_redirect_valid_o),
    .pc_redirect_addr_o       (pc_redirect_addr_o),
    .trap_busy_o              (trap_busy_o)
  );

  always #5 z_clk = ~z_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
  endtask

  task automatic clr_inputs();
    exception_valid_i        = 1'b0;
    exception_id_i           = 8'd0;
    exception_pc_i           = 32'd0;
    exception_tval_i         = 32'd0;
    exception_handler_addr_i = 32'd0;
    mret_valid_i             = 1'b0;
    csr_mepc_i               = 32'd0;
    stall_valid_i            = 1'b0;
    debug_mode_valid_i       = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge z_clk);
      #1;
    end
  endtask

  task automatic drive_exc(input logic [7:0] id, input logic [31:0] pc, input logic [31:0] tval,
                           input logic [31:0] h);
    exception_valid_i        = 1'b1;
    exception_id_i           = id;
    exception_pc_i           = pc;
    exception_tval_i         = tval;
    exception_handler_addr_i = h;
  endtask

  task automatic push_trap(input logic [7:0] id, input logic [31:0] pc, input logic [31:0] tval,
                           input logic [31:0] h);
    exp_t e;
    e.is_redir = 1'b0;
    e.mcause   = 32'(id);
    e.mepc     = {pc[31:2], 2'b00};
    e.mtval    = (id == 8'd11) ? 32'd0 : tval;
    e.addr     = 32'd0;
    e.mie      = m_mie;
    e.mpie     = m_mpie;
    sb_q.push_back(e);
    e.is_redir = 1'b1;
    e.addr     = h;
    e.mie      = 1'b0;
    e.mpie     = m_mie;
    sb_q.push_back(e);
    m_mpie = m_mie;
    m_mie  = 1'b0;
  endtask

  task automatic push_mret(input logic [31:0] mepc);
    exp_t e;
    e.is_redir = 1'b1;
    e.mcause   = 32'd0;
    e.mepc     = 32'd0;
    e.mtval    = 32'd0;
    e.addr     = mepc;
    e.mie      = m_mie;
    e.mpie     = m_mpie;
    sb_q.push_back(e);
    m_mie  = m_mpie;
    m_mpie = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the sequencer back in IDLE.
  task automatic do_trap(input logic [7:0] id, input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] h);
    drive_exc(id, pc, tval, h);
    push_trap(id, pc, tval, h);
    tick(1);
    clr_inputs();
    @(negedge z_clk);
    check_eq("lat_we_n1", 32'(csr_trap_we_o), 32'd1);
    @(negedge z_clk);
    check_eq("lat_redir_n2", 32'(pc_redirect_valid_o), 32'd1);
    tick(1);
  endtask

  task automatic do_mret(input logic [31:0] mepc);
    mret_valid_i = 1'b1;
    csr_mepc_i   = mepc;
    push_mret(mepc);
    tick(1);
    clr_inputs();
    @(negedge z_clk);
    check_eq("lat_ret_n1", 32'(pc_redirect_valid_o), 32'd1);
    tick(1);
  endtask

  // Retire queued expectations whenever the DUT strobes a CSR write or redirect.
  always @(negedge z_clk) begin
    if (!z_rst) begin
      check_eq("flush_vs_strobes", 32'(flush_o), 32'(csr_trap_we_o | pc_redirect_valid_o));
      check_eq("busy_vs_flush", 32'(trap_busy_o), 32'(flush_o));
      if (csr_trap_we_o || pc_redirect_valid_o) begin
        check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("sb_kind", 32'(pc_redirect_valid_o), 32'(mon_e.is_redir));
          if (!mon_e.is_redir) begin
            check_eq("mcause", csr_mcause_o, mon_e.mcause);
            check_eq("mepc", csr_mepc_o, mon_e.mepc);
            check_eq("mtval", csr_mtval_o, mon_e.mtval);
          end else begin
            check_eq("redir_addr", pc_redirect_addr_o, mon_e.addr);
          end
          check_eq("sb_mie", 32'(mstatus_mie_o), 32'(mon_e.mie));
          check_eq("sb_mpie", 32'(mstatus_mpie_o), 32'(mon_e.mpie));
        end
      end
    end
  end

  initial begin
    clr_inputs();
    m_mie  = 1'b0;
    m_mpie = 1'b0;
    z_rst  = 1'b1;
    tick(2);
    check_eq("rst_we", 32'(csr_trap_we_o), 32'd0);
    check_eq("rst_redir", 32'(pc_redirect_valid_o), 32'd0);
    check_eq("rst_flush", 32'(flush_o), 32'd0);
    check_eq("rst_busy", 32'(trap_busy_o), 32'd0);
    check_eq("rst_mie", 32'(mstatus_mie_o), 32'd0);
    check_eq("rst_mpie", 32'(mstatus_mpie_o), 32'd0);
    check_eq("rst_mcause", csr_mcause_o, 32'd0);
    check_eq("rst_mepc", csr_mepc_o, 32'd0);
    check_eq("rst_mtval", csr_mtval_o, 32'd0);
    check_eq("rst_addr", pc_redirect_addr_o, 32'd0);
    z_rst = 1'b0;
    tick(2);

    // Two MRETs walk MPIE->MIE up to MIE=1.
    do_mret(32'h0000_0040);
    do_mret(32'h0000_0080);
    check_eq("mie_set", 32'(mstatus_mie_o), 32'd1);
    check_eq("mpie_set", 32'(mstatus_mpie_o), 32'd1);

    // Load misalign.
    do_trap(8'd4, 32'h0000_0100, 32'h0000_2003, 32'h0000_0400);
    check_eq("ldmis_mie", 32'(mstatus_mie_o), 32'd0);
    check_eq("ldmis_mpie", 32'(mstatus_mpie_o), 32'd1);
    do_mret(32'h0000_0104);

    // ecall (mtval zeroed, unaligned pc) then MRET.
    do_trap(8'd11, 32'h0000_0103, 32'h0000_DEAD, 32'h0000_0400);
    do_mret(32'h0000_0104);
    check_eq("ecall_ret_mie", 32'(mstatus_mie_o), 32'd1);
    check_eq("ecall_ret_mpie", 32'(mstatus_mpie_o), 32'd1);

    // Exception and MRET together: exception wins.
    drive_exc(8'd2, 32'h0000_0208, 32'h0000_0013, 32'h0000_0500);
    mret_valid_i = 1'b1;
    csr_mepc_i   = 32'h0000_0999;
    push_trap(8'd2, 32'h0000_0208, 32'h0000_0013, 32'h0000_0500);
    tick(1);
    clr_inputs();
    tick(3);

    // Exception held under stall, then released.
    drive_exc(8'd6, 32'h0000_0300, 32'h0000_3001, 32'h0000_0600);
    stall_valid_i = 1'b1;
    repeat (3) begin
      @(negedge z_clk);
      check_eq("stall_no_we", 32'(csr_trap_we_o), 32'd0);
      tick(1);
    end
    stall_valid_i = 1'b0;
    push_trap(8'd6, 32'h0000_0300, 32'h0000_3001, 32'h0000_0600);
    tick(1);
    clr_inputs();
    @(negedge z_clk);
    check_eq("stall_release_we", 32'(csr_trap_we_o), 32'd1);
    tick(3);

    // Debug mode suppresses both trap and MRET.
    drive_exc(8'd4, 32'h0000_0310, 32'h0000_3101, 32'h0000_0610);
    mret_valid_i       = 1'b1;
    debug_mode_valid_i = 1'b1;
    repeat (3) begin
      @(negedge z_clk);
      check_eq("dbg_no_we", 32'(csr_trap_we_o), 32'd0);
      check_eq("dbg_no_redir", 32'(pc_redirect_valid_o), 32'd0);
      tick(1);
    end
    clr_inputs();
    tick(2);

    // Re-arm MIE, then trap A, ignored B during CAPTURE/REDIRECT, back-to-back C.
    do_mret(32'h0000_0044);
    do_mret(32'h0000_0048);
    drive_exc(8'd0, 32'h0000_0400, 32'h0000_0401, 32'h0000_0700);
    push_trap(8'd0, 32'h0000_0400, 32'h0000_0401, 32'h0000_0700);
    tick(1);
    drive_exc(8'd2, 32'h0000_0BAD, 32'h0000_0BAD, 32'h0000_0B00);
    tick(2);
    drive_exc(8'd24, 32'h0000_0500, 32'h8000_0000, 32'h0000_0740);
    push_trap(8'd24, 32'h0000_0500, 32'h8000_0000, 32'h0000_0740);
    tick(1);
    clr_inputs();
    tick(4);
    check_eq("b2b_mie", 32'(mstatus_mie_o), 32'(m_mie));
    check_eq("b2b_mpie", 32'(mstatus_mpie_o), 32'(m_mpie));

    // Reset during CAPTURE.
    drive_exc(8'd4, 32'h0000_0900, 32'h0000_0901, 32'h0000_0A00);
    tick(1);
    clr_inputs();
    #1;
    z_rst = 1'b1;
    #1;
    check_eq("midrst_we", 32'(csr_trap_we_o), 32'd0);
    check_eq("midrst_flush", 32'(flush_o), 32'd0);
    check_eq("midrst_busy", 32'(trap_busy_o), 32'd0);
    check_eq("midrst_mcause", csr_mcause_o, 32'd0);
    check_eq("midrst_mpie", 32'(mstatus_mpie_o), 32'd0);
    m_mie  = 1'b0;
    m_mpie = 1'b0;
    tick(1);
    z_rst = 1'b0;
    repeat (4) begin
      @(negedge z_clk);
      check_eq("postrst_busy", 32'(trap_busy_o), 32'd0);
      check_eq("postrst_redir", 32'(pc_redirect_valid_o), 32'd0);
    end

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/z_trap_sequencer.md
Name: z_trap_sequencer

Overview:
- Consumer side of the exception-detect interface.
- Takes the registered-free exception_valid/exception_id/handler-address/fault-address outputs of the exception detector and sequences the trap. It writes mcause/mepc/mtval, updates mstatus MIE/MPIE, flushes the pipeline and redirects fetch to the handler.
- Also sequences the return path (MRET) back to mepc.
- Sits between the execute-stage exception detector, the CSR file and the fetch PC mux.

Parameters:
- DATA_WIDTH, 32, width of CSR values and fault addresses.
- PC_WIDTH, 32, width of program counter.

Ports:
- z_clk  input  1  core clock.
- z_rst  input  1  asynchronous, active-high reset.
- exception_valid_i  input  1  exception detected this cycle (from detector).
- exception_id_i  input  8  cause code: 0 instr misalign, 2 illegal, 4 ld misalign, 6 sd misalign, 11 ecall, 24 mem out of bound.
- exception_pc_i  input  PC_WIDTH  PC of the faulting instruction.
- exception_tval_i  input  DATA_WIDTH  fault value: misaligned/out-of-bound address or illegal instruction word.
- exception_handler_addr_i  input  DATA_WIDTH  trap vector, already 4-byte aligned.
- mret_valid_i  input  1  MRET retiring this cycle.
- csr_mepc_i  input  PC_WIDTH  current mepc from the CSR file.
- stall_valid_i  input  1  pipeline stall; inputs are not sampled while high.
- debug_mode_valid_i  input  1  core in debug mode; suppresses traps and MRET.
- csr_trap_we_o  output  1  one-cycle pulse: CSR file loads mcause/mepc/mtval.
- csr_mcause_o  output  DATA_WIDTH  mcause value.
- csr_mepc_o  output  PC_WIDTH  mepc value.
- csr_mtval_o  output  DATA_WIDTH  mtval value.
- mstatus_mie_o  output  1  machine interrupt enable.
- mstatus_mpie_o  output  1  previous MIE.
- flush_o  output  1  kill all in-flight instructions.
- pc_redirect_valid_o  output  1  one-cycle fetch redirect strobe.
- pc_redirect_addr_o  output  PC_WIDTH  redirect target.
- trap_busy_o  output  1  sequencer not IDLE.

Behaviour:
- **Reset** (z_rst high, async): state IDLE. All outputs 0, including MIE and MPIE. Latched id/pc/tval/target are cleared to 0.
- **FSM states:** IDLE, CAPTURE, REDIRECT, RETURN.
- **IDLE**, sampled only when stall_valid_i=0 and debug_mode_valid_i=0:
  - exception_valid_i=1: latch id, pc, tval and handler address; go to CAPTURE.
  - else mret_valid_i=1: latch csr_mepc_i as target; go to RETURN.
  - Both high in the same cycle: exception wins and MRET is dropped.
- **CAPTURE** (1 cycle):
  - csr_trap_we_o=1 and flush_o=1.
  - csr_mcause_o = zero-extended id, MSB=0.
  - csr_mepc_o = latched pc with bits[1:0] forced to 0.
  - csr_mtval_o = latched tval, except 0 when id=11.
  - At the clock edge: MPIE<=MIE, MIE<=0. Go to REDIRECT.
- **REDIRECT** (1 cycle):
  - pc_redirect_valid_o=1, pc_redirect_addr_o = latched handler address, flush_o=1.
  - Go to IDLE.
- **RETURN** (1 cycle):
  - pc_redirect_valid_o=1, pc_redirect_addr_o = latched mepc, flush_o=1.
  - At the edge: MIE<=MPIE, MPIE<=1. Go to IDLE.
- **Latency:** exception sampled at edge N gives csr_trap_we_o high in cycle N+1 and redirect in cycle N+2. MRET sampled at N gives redirect in N+1.
- **Busy:** exception_valid_i and mret_valid_i are ignored while not IDLE; those instructions are flushed anyway. trap_busy_o is high in CAPTURE, REDIRECT and RETURN.
- **Non-IDLE sequencing:** CAPTURE, REDIRECT and RETURN always complete; they are not gated by stall_valid_i or debug_mode_valid_i.
- **Register values outside active states:**
  - csr_mcause/mepc/mtval_o hold their last values.
  - pc_redirect_addr_o holds its last value.
  - Strobes (csr_trap_we_o, pc_redirect_valid_o, flush_o) are 0.
- **Cause codes:** synchronous exceptions are taken regardless of MIE. An unlisted id with valid=1 is still taken, with mcause = id.
- **Back-to-back traps:** a trap immediately after REDIRECT is legal. It overwrites mepc and copies MIE(=0) into MPIE.
- **Reset mid-sequence:** returns to IDLE immediately with no CSR write or redirect.

Test Plan:
- ld misalign: id=4, pc=0x100, tval=0x2003, handler=0x400, MIE=1 → cycle N+1: we=1, mcause=4, mepc=0x100, mtval=0x2003; cycle N+2: redirect to 0x400; afterwards MIE=0, MPIE=1.
- ecall: id=11, tval=0xDEAD → mtval=0, mcause=11. Then MRET with csr_mepc_i=0x104 → redirect 0x104 one cycle later; MIE=1, MPIE=1.
- Simultaneous exception (id=2) and mret_valid_i → trap taken, no RETURN redirect, mcause=2.
- Exception held while stall_valid_i=1 for 3 cycles → no response until stall drops; then we=1 on the next cycle. Exception with debug_mode_valid_i=1 → no CSR write and no redirect.
- Second exception asserted during CAPTURE/REDIRECT → ignored; exactly one we pulse and one redirect.
- Assert z_rst in CAPTURE → all outputs 0 asynchronously; after release trap_busy_o=0 and no redirect occurs.
